cpu_seq_alu: RTL and testbench

- Combined instruction sequencer and arithmetic unit for the 8-bit, 3-bit-opcode accumulator CPU.
- An 8-phase controller issues the memory, register and PC strobes for each instruction.
- A combinational ALU combines the memory data bus with the accumulator.
- Sits between the IR/accumulator/PC registers and the memory/address mux; one clock input replaces a free-running clock source.

---
 rtl/cpu_seq_alu.sv | 138 +++++++++++++
 tb/tb_cpu_seq_alu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_alu.sv
// Sequencer and ALU for the 8-bit accumulator CPU; optional `SEQ_PHASE_OUT_EN` exposes the phase register.
// Latency: ALU and strobes are combinational off the phase register; one instruction spans exactly 8 clocks.
// Backpressure: none; the phase counter free-runs except when parked at phase 4 by HLT.
module cpu_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             sel,
    output logic             rd,
    output logic             wr,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             halt,
`ifdef SEQ_PHASE_OUT_EN
    output logic             data_e,
    output logic [2:0]       phase
`else
    output logic             data_e
`endif
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    logic [2:0] phase_q;
    logic [2:0] phase_d;
    logic       aluop;
    logic       is_hlt;

    assign is_hlt = (opcode == OP_HLT);
    assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        alu_out = accum;
        unique case (opcode)
            OP_ADD:  alu_out = data + accum;
            OP_AND:  alu_out = data & accum;
            OP_XOR:  alu_out = data ^ accum;
            OP_LDA:  alu_out = data;
            default: alu_out = accum;
        endcase
    end

    assign zero = (accum == '0);

    // HLT parks the counter at OP_ADDR; only reset releases it.
    always_comb begin
        phase_d = phase_q + 3'd1;
        if (phase_q == PH_OP_ADDR && is_hlt) begin
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef SEQ_PHASE_OUT_EN
    assign phase = phase_q;
`endif

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        unique case (phase_q)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                halt   = is_hlt;
                inc_pc = !is_hlt;
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_alu.sv
// Directed bench for cpu_seq_alu: per-phase strobe patterns for each opcode class, ALU results, HLT parking.
module tb_cpu_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic [7:0] data;
    logic [7:0] accum;
    logic [7:0] alu_out;
    logic       zero, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e;
`ifdef SEQ_PHASE_OUT_EN
    logic [2:0] phase_w;
`endif

    int checks = 0;
    int passed = 0;

    logic [7:0] o_sel, o_rd, o_wr, o_ld_ir, o_ld_ac, o_ld_pc, o_inc_pc, o_halt, o_data_e;

    always #5 clk = ~clk;

    cpu_seq_alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .data    (data),
        .accum   (accum),
        .alu_out (alu_out),
        .zero    (zero),
        .sel     (sel),
        .rd      (rd),
        .wr      (wr),
        .ld_ir   (ld_ir),
        .ld_ac   (ld_ac),
        .ld_pc   (ld_pc),
        .inc_pc  (inc_pc),
        .halt    (halt),
`ifdef SEQ_PHASE_OUT_EN
        .data_e  (data_e),
        .phase   (phase_w)
`else
        .data_e  (data_e)
`endif
    );

    // Resets, then records each strobe over phases 0..7 (bit i = phase i); returns sampling cycle 8.
    task automatic capture_instr(input logic [2:0] op, input logic [7:0] acc);
        opcode = op;
        accum  = acc;
        rst_n  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            o_sel[i]    = sel;
            o_rd[i]     = rd;
            o_wr[i]     = wr;
            o_ld_ir[i]  = ld_ir;
            o_ld_ac[i]  = ld_ac;
            o_ld_pc[i]  = ld_pc;
            o_inc_pc[i] = inc_pc;
            o_halt[i]   = halt;
            o_data_e[i] = data_e;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        opcode = 3'd2;
        rst_n  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ctl = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e};
        checks++;
        if (ctl !== 9'b1_0000_0000) $display("FAIL reset_ctrl got=%b exp=%b", ctl, 9'b1_0000_0000);
        else passed++;
        // Reset held across several edges must keep phase at 0.
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sel, rd} !== 2'b10) $display("FAIL reset_hold got sel,rd=%b exp=10", {sel, rd});
        else passed++;
`ifdef SEQ_PHASE_OUT_EN
        checks++;
        if (phase_w !== 3'd0) $display("FAIL reset_phase got=%0d exp=0", phase_w);
        else passed++;
`endif
    endtask

    task automatic test_add_sequence();
        data = 8'hF0;
        capture_instr(3'd2, 8'h3C);
        checks++;
        if (o_sel !== 8'h0F) $display("FAIL add_sel got=%b exp=%b", o_sel, 8'h0F);
        else passed++;
        checks++;
        if (o_ld_ir !== 8'h0C) $display("FAIL add_ld_ir got=%b exp=%b", o_ld_ir, 8'h0C);
        else passed++;
        checks++;
        if (o_inc_pc !== 8'h10) $display("FAIL add_inc_pc got=%b exp=%b", o_inc_pc, 8'h10);
        else passed++;
        checks++;
        if (o_ld_ac !== 8'h80) $display("FAIL add_ld_ac got=%b exp=%b", o_ld_ac, 8'h80);
        else passed++;
        checks++;
        if (o_rd !== 8'hEE) $display("FAIL add_rd got=%b exp=%b", o_rd, 8'hEE);
        else passed++;
        checks++;
        if ((o_wr | o_ld_pc | o_halt | o_data_e) !== 8'h00)
            $display("FAIL add_quiet got=%b exp=00000000", o_wr | o_ld_pc | o_halt | o_data_e);
        else passed++;
        // Cycle 8: wrapped back to phase 0 (sel=1, rd=0).
        checks++;
        if ({sel, rd} !== 2'b10) $display("FAIL add_wrap got sel,rd=%b exp=10", {sel, rd});
        else passed++;
    endtask

    task automatic test_alu();
        logic [2:0] ops [7];
        logic [7:0] exp [7];
        ops = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
        exp = '{8'h2C, 8'h30, 8'hCC, 8'hF0, 8'h3C, 8'h3C, 8'h3C};
        data  = 8'hF0;
        accum = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (alu_out !== exp[i]) $display("FAIL alu_op%0d got=%h exp=%h", ops[i], alu_out, exp[i]);
            else passed++;
        end
        opcode = 3'd2;
        data   = 8'hFF;
        accum  = 8'h01;
        #1;
        checks++;
        if (alu_out !== 8'h00) $display("FAIL alu_add_wrap got=%h exp=00", alu_out);
        else passed++;
        checks++;
        if (zero !== 1'b0) $display("FAIL zero_acc1 got=%b exp=0", zero);
        else passed++;
        accum = 8'h00;
        #1;
        checks++;
        if (zero !== 1'b1) $display("FAIL zero_acc0 got=%b exp=1", zero);
        else passed++;
    endtask

    task automatic test_skz();
        capture_instr(3'd1, 8'h00);
        checks++;
        if (o_inc_pc !== 8'h50) $display("FAIL skz_z_inc_pc got=%b exp=%b", o_inc_pc, 8'h50);
        else passed++;
        checks++;
        if (o_rd !== 8'h0E) $display("FAIL skz_rd got=%b exp=%b", o_rd, 8'h0E);
        else passed++;
        capture_instr(3'd1, 8'h05);
        checks++;
        if (o_inc_pc !== 8'h10) $display("FAIL skz_nz_inc_pc got=%b exp=%b", o_inc_pc, 8'h10);
        else passed++;
    endtask

    task automatic test_sto();
        capture_instr(3'd6, 8'h3C);
        checks++;
        if (o_data_e !== 8'hC0) $display("FAIL sto_data_e got=%b exp=%b", o_data_e, 8'hC0);
        else passed++;
        checks++;
        if (o_wr !== 8'h80) $display("FAIL sto_wr got=%b exp=%b", o_wr, 8'h80);
        else passed++;
        checks++;
        if (o_rd !== 8'h0E) $display("FAIL sto_rd got=%b exp=%b", o_rd, 8'h0E);
        else passed++;
        checks++;
        if (o_ld_ac !== 8'h00) $display("FAIL sto_ld_ac got=%b exp=00000000", o_ld_ac);
        else passed++;
    endtask

    task automatic test_jmp();
        capture_instr(3'd7, 8'h3C);
        checks++;
        if (o_ld_pc !== 8'h80) $display("FAIL jmp_ld_pc got=%b exp=%b", o_ld_pc, 8'h80);
        else passed++;
        checks++;
        if (o_ld_ac !== 8'h00) $display("FAIL jmp_ld_ac got=%b exp=00000000", o_ld_ac);
        else passed++;
    endtask

    task automatic test_hlt();
        int held;
        capture_instr(3'd0, 8'h3C);
        // Phases 0..3 ran normally, then the counter parked at 4.
        checks++;
        if (o_halt !== 8'hF0) $display("FAIL hlt_halt got=%b exp=%b", o_halt, 8'hF0);
        else passed++;
        checks++;
        if (o_inc_pc !== 8'h00) $display("FAIL hlt_inc_pc got=%b exp=00000000", o_inc_pc);
        else passed++;
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (halt === 1'b1 && sel === 1'b0 && inc_pc === 1'b0) held++;
        end
        checks++;
        if (held !== 20) $display("FAIL hlt_hold got=%0d exp=20 cycles", held);
        else passed++;
`ifdef SEQ_PHASE_OUT_EN
        checks++;
        if (phase_w !== 3'd4) $display("FAIL hlt_phase got=%0d exp=4", phase_w);
        else passed++;
`endif
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({halt, sel, rd} !== 3'b010) $display("FAIL hlt_reset got halt,sel,rd=%b exp=010", {halt, sel, rd});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sel, rd, halt} !== 3'b110) $display("FAIL hlt_restart got sel,rd,halt=%b exp=110", {sel, rd, halt});
        else passed++;
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd0;
        data   = 8'h00;
        accum  = 8'h00;
        @(negedge clk);
        test_reset();
        test_add_sequence();
        test_alu();
        test_skz();
        test_sto();
        test_jmp();
        test_hlt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
